// File: rtl/dmem_bytelane_ram.sv
// dmem_bytelane_ram: byte-lane data RAM with sized loads, misalign detection and zero-clear sequencer
module dmem_bytelane_ram #(
  parameter int DEPTH_LOG2     = 5,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        misalign,
  input  logic        clear_start,
  output logic        busy
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state;
  logic [DEPTH_LOG2-1:0] idx, widx;
  logic [31:0] mem [DEPTH];
  logic accept, bad, load_ok;
  logic [3:0] be;
  logic [31:0] wlane, word, shifted, ext;
  assign req_ready = state == IDLE;
  assign busy = state == CLEAR;
  assign accept = req_valid && req_ready;
  assign bad = (req_size == 2'b11) || (req_size == 2'b01 && addr[0]) || (req_size == 2'b10 && addr[1:0] != 2'b00);
  assign load_ok = accept && !req_we && !bad;
  assign widx = addr[DEPTH_LOG2+1:2];
  // lane enables and lane-replicated store data so every lane sees its byte
  assign be = req_size == 2'b00 ? 4'b0001 << addr[1:0] : req_size == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wlane = req_size == 2'b00 ? {4{wdata[7:0]}} : req_size == 2'b01 ? {2{wdata[15:0]}} : wdata;
  // load path: right-justify the selected lanes, then extend
  assign word = mem[widx];
  assign shifted = word >> {addr[1:0], 3'b000};
  assign ext = req_size == 2'b00 ? {{24{req_signed & shifted[7]}}, shifted[7:0]}
             : req_size == 2'b01 ? {{16{req_signed & shifted[15]}}, shifted[15:0]} : shifted;
  // array write port: clear sequencer has priority, otherwise aligned stores by lane
  always_ff @(posedge clk) begin
    if (busy) mem[idx] <= '0;
    else if (accept && req_we && !bad)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[widx][8*b +: 8] <= wlane[8*b +: 8];
  end
  // control state, clear index and registered load response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= CLEAR_ON_RESET ? CLEAR : IDLE;
      idx         <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      misalign    <= 1'b0;
    end else begin
      rdata_valid <= load_ok;
      misalign    <= accept && bad;
      if (load_ok) rdata <= ext;
      if (state == CLEAR) begin
        idx <= idx + 1'b1;
        if (&idx) state <= IDLE;
      end else if (clear_start) begin
        state <= CLEAR;
        idx   <= '0;
      end
    end
  end
endmodule
